// File: rtl/tdc_mc_uart_pkg.sv
// tdc_mc_uart shared types and helpers.
// State encoding, sync byte and frame length.
package tdc_pkg;

  typedef enum logic [1:0] {
    TDC_IDLE    = 2'd0,
    TDC_MEASURE = 2'd1,
    TDC_SEND    = 2'd2
  } tdc_state_e;

  localparam logic [7:0] TDC_SYNC_BYTE = 8'hA5;

  function automatic int tdc_frame_bytes(
    input int channels,
    input int cnt_w
  );
    return 2 + channels * (cnt_w / 8);
  endfunction

endpackage

// File: rtl/tdc_mc_uart_if.sv
// tdc_mc_uart pin bundle.
// Driver side is master, the TDC is slave.
interface tdc_mc_uart_if #(
  parameter int CHANNELS = 2
);
  logic                start;
  logic [CHANNELS-1:0] stop;
  logic                uart_tx;
  logic                busy;

  modport master (
    output start,
    output stop,
    input  uart_tx,
    input  busy
  );

  modport slave (
    input  start,
    input  stop,
    output uart_tx,
    output busy
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first.
// ready rises as the stop bit ends so bytes chain without gaps.
module uart_tx_byte #(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int DW = $clog2(CLK_DIV);

  logic          active;
  logic [8:0]    frame;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          bit_end;

  assign bit_end = div_cnt == DW'(CLK_DIV - 1);
  assign ready   = !active || (bit_end && bit_cnt == 4'd9);

  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= 1'b0;
      frame   <= '1;
      bit_cnt <= '0;
      div_cnt <= '0;
      tx      <= 1'b1;
    end else if (valid && ready) begin
      active  <= 1'b1;
      frame   <= {1'b1, data};
      bit_cnt <= '0;
      div_cnt <= '0;
      tx      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        div_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          tx      <= frame[0];
          frame   <= {1'b1, frame[8:1]};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tdc_mc_uart.sv
// Multi-channel TDC: start arms a counter, each stop latches it,
// then the set is reported as {A5, results MSB first, status}.
import tdc_pkg::*;

module tdc_mc_uart #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int CLK_DIV  = 104
) (
  input logic           clk,
  input logic           rst,
  tdc_mc_uart_if.slave  io
);
  localparam int NB   = tdc_frame_bytes(CHANNELS, CNT_W);
  localparam int BI_W = $clog2(NB + 1);
  localparam int BPC  = CNT_W / 8;

  localparam logic [1:0] IDLE    = TDC_IDLE;
  localparam logic [1:0] MEASURE = TDC_MEASURE;
  localparam logic [1:0] SEND    = TDC_SEND;

  logic [CHANNELS:0]   s1, s2, s3, edge_q;
  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    result [CHANNELS];
  logic [CHANNELS-1:0] flags, tmo, nxt_flags;
  logic [CHANNELS-1:0] stop_e;
  logic [BI_W-1:0]     byte_idx;
  logic                start_e, sat;
  logic                tx_valid, tx_ready;
  logic [7:0]          tx_data;
  logic [NB*8-1:0]     frame_v;

  assign start_e   = edge_q[0];
  assign stop_e    = edge_q[CHANNELS:1];
  assign sat       = &cnt;
  assign nxt_flags = flags | stop_e;
  assign tx_valid  = state == SEND && byte_idx != BI_W'(NB);
  assign io.busy   = state != IDLE;

  always_comb begin
    frame_v = '0;
    frame_v[NB*8-1 -: 8] = TDC_SYNC_BYTE;
    for (int i = 0; i < CHANNELS; i++)
      frame_v[(NB-1-i*BPC)*8-1 -: CNT_W] = result[i];
    frame_v[7:0] = 8'(tmo);
  end

  always_comb begin
    tx_data = '0;
    for (int k = 0; k < NB; k++)
      if (byte_idx == BI_W'(k))
        tx_data = frame_v[(NB-1-k)*8 +: 8];
  end

  // Start and stops share one sync/edge path so latency cancels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      edge_q   <= '0;
      state    <= IDLE;
      cnt      <= '0;
      flags    <= '0;
      tmo      <= '0;
      byte_idx <= '0;
      for (int i = 0; i < CHANNELS; i++)
        result[i] <= '0;
    end else begin
      s1     <= {io.stop, io.start};
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 & ~s3;
      unique case (state)
        IDLE: begin
          if (start_e) begin
            cnt   <= CNT_W'(1);
            flags <= '0;
            tmo   <= '0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          cnt <= cnt + 1'b1;
          for (int i = 0; i < CHANNELS; i++) begin
            if (stop_e[i] && !flags[i]) begin
              result[i] <= cnt;
            end else if (sat && !flags[i]) begin
              result[i] <= '1;
              tmo[i]    <= 1'b1;
            end
          end
          flags <= sat ? '1 : nxt_flags;
          if (sat || &nxt_flags) begin
            byte_idx <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (tx_valid) byte_idx <= byte_idx + 1'b1;
            else          state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx   (io.uart_tx)
  );
endmodule

// File: tb/tb_tdc_mc_uart.sv
// Scoreboard bench for tdc_mc_uart: expected bytes are queued
// with the stimulus and matched against a UART line decoder.
module tb_tdc_mc_uart;
  localparam int CH  = 2;
  localparam int CW  = 16;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tdc_mc_uart_if #(.CHANNELS(CH)) io ();

  tdc_mc_uart #(
    .CHANNELS(CH),
    .CNT_W   (CW),
    .CLK_DIV (DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int checks = 0;
  int fails  = 0;
  logic [9:0] rx_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] e, r;
  bit ok;

  // Line decoder: entry = {stop, data[7:0], start} sampled mid-bit.
  initial begin : mon
    logic [9:0] b;
    forever begin
      @(negedge clk);
      if (io.uart_tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        b[0] = io.uart_tx;
        for (int k = 1; k < 10; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = io.uart_tx;
        end
        rx_q.push_back(b);
      end
    end
  end

  task automatic exp_push(input logic [47:0] f);
    for (int k = 0; k < 6; k++)
      exp_q.push_back({1'b1, f[47-8*k -: 8], 1'b0});
  endtask

  task automatic drive_seq(input int off0, input int off1, input int len);
    io.start = 1'b0;
    io.stop  = '0;
    repeat (5) @(posedge clk);
    for (int c = 0; c <= len; c++) begin
      @(posedge clk);
      #1;
      if (c == 0)    io.start  = 1'b1;
      if (c == off0) io.stop[0] = 1'b1;
      if (c == off1) io.stop[1] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    io.start = 1'b0;
    io.stop  = '0;
  endtask

  task automatic wait_rx(input int n, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rx_q.size() >= n) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (io.uart_tx !== 1'b1) begin
        fails++;
        $display("FAIL rst_tx%0d: got %b expected 1", i, io.uart_tx);
      end
      checks++;
      if (io.busy !== 1'b0) begin
        fails++;
        $display("FAIL rst_busy%0d: got %b expected 0", i, io.busy);
      end
      io.start = ~io.start;
      io.stop  = ~io.stop;
    end
    io.start = 1'b0;
    io.stop  = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (io.busy !== 1'b0 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL rst_idle: busy %b bytes %0d expected 0 0",
               io.busy, rx_q.size());
    end
  endtask

  task automatic test_normal();
    int n, t;
    exp_push(48'hA5_0025_00C8_00);
    io.start = 1'b0;
    io.stop  = '0;
    repeat (5) @(posedge clk);
    for (int c = 0; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 0)   io.start   = 1'b1;
      if (c == 37)  io.stop[0] = 1'b1;
      if (c == 200) io.stop[1] = 1'b1;
      if (c == 3) begin
        checks++;
        if (io.busy !== 1'b0) begin
          fails++;
          $display("FAIL busy_early: got %b expected 0", io.busy);
        end
      end
      if (c == 4) begin
        checks++;
        if (io.busy !== 1'b1) begin
          fails++;
          $display("FAIL busy_rise: got %b expected 1", io.busy);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    io.start = 1'b0;
    io.stop  = '0;
    n = 0;
    while (io.uart_tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    t = 0;
    while (io.busy === 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != 240) begin
      fails++;
      $display("FAIL norm_len: got %0d cycles expected 240", t);
    end
    wait_rx(6, 100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL norm_frame: got %0d bytes expected 6", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      for (int k = 0; k < 6; k++) begin
        e = exp_q.pop_front();
        r = rx_q.pop_front();
        checks++;
        if (r !== e) begin
          fails++;
          $display("FAIL norm_byte%0d: got %h expected %h", k, r, e);
        end
      end
    end
  endtask

  task automatic test_timeout_coincident();
    exp_push(48'hA5_0025_FFFF_02);
    drive_seq(37, 0, 40);
    wait_rx(6, 70000, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL tmo_frame: got %0d bytes expected 6", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      for (int k = 0; k < 6; k++) begin
        e = exp_q.pop_front();
        r = rx_q.pop_front();
        checks++;
        if (r !== e) begin
          fails++;
          $display("FAIL tmo_byte%0d: got %h expected %h", k, r, e);
        end
      end
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (io.busy !== 1'b0) begin
      fails++;
      $display("FAIL tmo_done: busy %b expected 0", io.busy);
    end
  endtask

  task automatic test_ignored();
    exp_push(48'hA5_0025_00C8_00);
    io.start = 1'b0;
    io.stop  = '0;
    repeat (5) @(posedge clk);
    for (int c = 0; c <= 330; c++) begin
      @(posedge clk);
      #1;
      if (c == 0)   io.start   = 1'b1;
      if (c == 37)  io.stop[0] = 1'b1;
      if (c == 50)  io.start   = 1'b0;
      if (c == 60)  io.stop[0] = 1'b0;
      if (c == 80)  io.stop[0] = 1'b1;
      if (c == 100) io.start   = 1'b1;
      if (c == 200) io.stop[1] = 1'b1;
      if (c >= 210 && c % 8 == 0) begin
        io.start   = ~io.start;
        io.stop[0] = ~io.stop[0];
      end
    end
    io.start = 1'b0;
    io.stop  = '0;
    wait_rx(6, 400, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL ign_frame: got %0d bytes expected 6", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      for (int k = 0; k < 6; k++) begin
        e = exp_q.pop_front();
        r = rx_q.pop_front();
        checks++;
        if (r !== e) begin
          fails++;
          $display("FAIL ign_byte%0d: got %h expected %h", k, r, e);
        end
      end
    end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (io.busy !== 1'b0 || rx_q.size() != 0) begin
      fails++;
      $display("FAIL ign_extra: busy %b bytes %0d expected 0 0",
               io.busy, rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive_seq(20, 30, 30);
    n = 0;
    while (io.uart_tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (95) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (io.uart_tx !== 1'b1) begin
      fails++;
      $display("FAIL mid_tx: got %b expected 1", io.uart_tx);
    end
    checks++;
    if (io.busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_busy: got %b expected 0", io.busy);
    end
    rst = 1'b1;
    repeat (60) @(posedge clk);
    rx_q.delete();
    exp_q.delete();
    exp_push(48'hA5_0005_0006_00);
    drive_seq(5, 6, 6);
    wait_rx(6, 400, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL mid_frame: got %0d bytes expected 6", rx_q.size());
      rx_q.delete();
      exp_q.delete();
    end else begin
      for (int k = 0; k < 6; k++) begin
        e = exp_q.pop_front();
        r = rx_q.pop_front();
        checks++;
        if (r !== e) begin
          fails++;
          $display("FAIL mid_byte%0d: got %h expected %h", k, r, e);
        end
      end
    end
  endtask

  initial begin
    io.start = 1'b0;
    io.stop  = '0;
    test_reset();
    test_normal();
    test_timeout_coincident();
    test_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/tdc_mc_uart.md
# tdc_mc_uart

Multi-channel time-to-digital converter with built-in UART reporting. One `start` edge arms a free-running cycle counter; each of `CHANNELS` independent `stop` inputs latches the elapsed cycle count on its first rising edge. The completed measurement set is then streamed out as a fixed-format 8N1 UART frame. It is the parametrised successor to the single-channel TDC top: it generalises channel count and counter width, and adds timeout handling and a status byte.

## Interface
- `CHANNELS`, 2: number of stop channels, 1..8.
- `CNT_W`, 16: counter/result width in bits. Must be a multiple of 8, from 8 to 32.
- `CLK_DIV`, 104: clock cycles per UART bit, ≥ 2.

- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous and active-low.
- `start` in 1: asynchronous start pulse; the rising edge is significant.
- `stop` in `CHANNELS`: asynchronous stop inputs, one per channel; rising edges are significant.
- `uart_tx` out 1: 8N1 serial output, LSB first, idles high.
- `busy` out 1: high while measuring or sending.

## Operation
- **Input conditioning.** `start` and each `stop` bit pass through a 2-FF synchroniser, then a rising-edge detector. All inputs see identical latency, so the latency cancels in the result.
- **State machine.** `IDLE → MEASURE → SEND → IDLE`.
- **IDLE.**
  - On a start edge: counter ← 1, all capture flags cleared, go to MEASURE.
  - Stop edges are ignored.
- **MEASURE.**
  - Counter increments by 1 per cycle.
  - A stop edge on channel *i* with flag *i* clear latches the current counter value into `result[i]` and sets the flag.
  - Later edges on the same channel are ignored.
  - Start edges are ignored.
- **Leaving MEASURE.**
  - All flags set: go to SEND.
  - Counter equals 2^CNT_W−1 on a cycle: every still-uncaptured channel latches all-ones and sets `timeout[i]`, then go to SEND.
  - A stop edge arriving on that same saturating cycle is a normal capture, with `timeout` clear.
- **Result definition.** A stop rising N cycles after the start rising edge yields N.
- **Start/stop coincidence.** A stop edge on the same cycle as the start edge is ignored, because the block is still in IDLE. That channel times out unless a later edge occurs.
- **SEND.** Transmits the bytes in this order:
  - Sync byte 0xA5.
  - For channel 0 up to `CHANNELS`−1: `result[i]`, CNT_W/8 bytes, MSB first.
  - Status byte: bit *i* = `timeout[i]`, upper bits 0.
  - Start, stop and stop-channel edges are all ignored during SEND.
  - After the last stop bit completes, go to IDLE.
- **Frame length.** 2 + CHANNELS·CNT_W/8 bytes; each byte is 10 bits (start, 8 data, stop).

## Timing
- **Reset values.**
  - `uart_tx` = 1, `busy` = 0, state IDLE.
  - Counter, results, flags and the synchroniser/edge-detector history all 0.
- **Reset mid-operation.** `rst` low on any cycle gives the reset values on the next edge. The frame is abandoned with no partial byte completion.
- **Start edge detection.** Occurs 3 cycles after a `start` rise (2 sync + 1 edge register). `busy` rises on the following cycle.
- **Bit timing.** Each UART bit holds for exactly `CLK_DIV` cycles. Bytes are back-to-back with no idle bit between them.
- **First start bit.** `uart_tx` falls on the first cycle after entering SEND.
- **End of frame.** `busy` falls on the cycle after the final stop bit ends; a new start edge is accepted on that same cycle.

## Structure
- **Package `tdc_pkg`:**
  - State enum (IDLE/MEASURE/SEND).
  - `TDC_SYNC_BYTE` = 8'hA5.
  - Byte-count helper `tdc_frame_bytes(CHANNELS, CNT_W)`.
- **Sub-module `uart_tx_byte` (parameter `CLK_DIV`):**
  - Interface: `clk`, `rst`, `data[7:0]`, `valid`, `ready`, `tx`.
  - `ready` is high on the cycle the stop bit finishes, enabling back-to-back bytes.
- **Top module contents:** synchronisers, capture logic, FSM, and a byte-index mux over `{sync, results, status}`.

## Test plan
Parameters for all scenarios: `CHANNELS`=2, `CNT_W`=16, `CLK_DIV`=4.
1. **Reset:** hold `rst` low for 3 cycles, inputs toggling → `uart_tx`=1 and `busy`=0 throughout, and no frame after release.
2. **Two normal captures:** `start` rise at t0, `stop[0]` at t0+37, `stop[1]` at t0+200 → frame A5 00 25 00 C8 00; each bit is 4 cycles; `busy` falls after 60 bit-times.
3. **Timeout:** `stop[0]` at t0+37, `stop[1]` never → after 65535 counts, frame A5 00 25 FF FF 02.
4. **Ignored edges:** extra `stop[0]` edges and a second `start` during MEASURE and SEND → frame identical to scenario 2.
5. **Coincident start/stop:** `stop[1]` rises on the same cycle as `start`, no later edge → `result[1]`=FFFF, status 02.
6. **Reset mid-frame:** `rst` low during the 3rd byte → `uart_tx`=1 and `busy`=0 on the next cycle; a new start with stops at +5 and +6 yields a complete frame A5 00 05 00 06 00.
